// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage MIPS pipeline. Resolves
//   load-use hazards, EX-stage redirects, multi-cycle MULT/DIV occupancy of
//   EX and the terminal syscall halt. Keeps saturating stall/flush counters
//   for the LED/segment display.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_*    source operands of the ID instruction
//   id_mdu_start             ID instruction is MULT/MULTU/DIV/DIVU
//   ex_memread/ex_regwrite/ex_wreg  EX instruction load/writeback info
//   ex_redirect, ex_halt     EX-stage redirect and syscall-exit
//   *_en, *_flush            pipeline register enables / synchronous clears
//   mdu_busy, halted         status
//   stall_cnt, flush_cnt     saturating statistics counters
module pipeline_hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_mdu_start,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_wreg,
  input  logic        ex_redirect,
  input  logic        ex_halt,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic        ex_mem_en,
  output logic        ex_mem_flush,
  output logic        mem_wb_en,
  output logic        mdu_busy,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MDU_WAIT, HALT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;
  logic             eval_run;
  logic             flush_inc;
  logic             stall_inc;

  assign load_use = ex_memread & ex_regwrite & (ex_wreg != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_wreg)) |
                     (id_uses_rt & (id_rt == ex_wreg)));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b1;
    mdu_busy     = 1'b0;
    halted       = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    eval_run     = 1'b0;
    flush_inc    = 1'b0;

    // During reset every output keeps its default value.
    if (!rst) begin
      case (state)
        HALT: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          halted      = 1'b1;
        end
        MDU_WAIT: begin
          if (cnt != '0) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
            mdu_busy     = 1'b1;
            cnt_nxt      = cnt - 1'b1;
          end else begin
            // Last MDU cycle behaves as RUN so a following MDU op can chain.
            eval_run = 1'b1;
          end
        end
        default: eval_run = 1'b1;
      endcase

      if (eval_run) begin
        state_nxt = RUN;
        if (ex_halt) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_nxt   = HALT;
        end else if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (id_mdu_start) begin
          state_nxt = MDU_WAIT;
          cnt_nxt   = CNT_W'(MDU_LATENCY - 1);
        end
      end
    end
  end

  // HALT-entry cycle is evaluated in RUN, so it is counted here naturally.
  assign stall_inc = !rst && !pc_en && (state != HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MDU_LATENCY=4).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_wreg;
  logic        id_uses_rs, id_uses_rt, id_mdu_start;
  logic        ex_memread, ex_regwrite, ex_redirect, ex_halt;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, ex_mem_flush, mem_wb_en, mdu_busy, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [9:0]  ctl;

  int errors = 0;
  int checks = 0;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
  //  ex_mem_en, ex_mem_flush, mem_wb_en, mdu_busy, halted}
  localparam logic [9:0] DEF   = 10'b11_01_0_101_00;
  localparam logic [9:0] LU    = 10'b00_01_1_101_00;
  localparam logic [9:0] RED   = 10'b11_11_1_101_00;
  localparam logic [9:0] HENT  = 10'b01_11_1_101_00;
  localparam logic [9:0] FRZ   = 10'b00_00_0_111_10;
  localparam logic [9:0] HLTD  = 10'b00_01_1_101_01;

  assign ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, ex_mem_flush, mem_wb_en, mdu_busy, halted};

  pipeline_hazard_ctrl #(.MDU_LATENCY(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
    .ex_wreg(ex_wreg), .ex_redirect(ex_redirect), .ex_halt(ex_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .ex_mem_flush(ex_mem_flush), .mem_wb_en(mem_wb_en), .mdu_busy(mdu_busy),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1; outputs are sampled at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_wreg = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_mdu_start = 0;
    ex_memread = 0; ex_regwrite = 0; ex_redirect = 0; ex_halt = 0;
  endtask

  task automatic set_load_use_rs();
    ex_memread = 1; ex_regwrite = 1; ex_wreg = 5'd8;
    id_rs = 5'd8; id_uses_rs = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    ex_halt = 1;
    set_load_use_rs();
    tick(); tick();
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL rst_forced_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL rst_flush_cnt got=%0d exp=0", flush_cnt); end
    tick();
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_no_count got=%0d exp=0", stall_cnt); end
    clear_inputs();
    rst = 0;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL idle_ctl got=%b exp=%b", ctl, DEF); end
    tick();
  endtask

  task automatic test_load_use();
    set_load_use_rs();
    #1;
    checks++; if (ctl !== LU) begin errors++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, LU); end
    tick();
    clear_inputs();
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    // rt path
    ex_memread = 1; ex_regwrite = 1; ex_wreg = 5'd9; id_rt = 5'd9; id_uses_rt = 1;
    #1;
    checks++; if (ctl !== LU) begin errors++; $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, LU); end
    tick();
    clear_inputs();
    #1;
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_rt_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_no_false_hazard();
    set_load_use_rs(); ex_wreg = 5'd0; id_rs = 5'd0;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL nf_r0_ctl got=%b exp=%b", ctl, DEF); end
    set_load_use_rs(); id_uses_rs = 0;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL nf_unused_ctl got=%b exp=%b", ctl, DEF); end
    set_load_use_rs(); ex_memread = 0;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL nf_alu_ctl got=%b exp=%b", ctl, DEF); end
    set_load_use_rs(); id_rs = 5'd7;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL nf_diffreg_ctl got=%b exp=%b", ctl, DEF); end
    tick();
    clear_inputs();
    #1;
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL nf_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_redirect_priority();
    set_load_use_rs(); ex_redirect = 1; id_mdu_start = 1;
    #1;
    checks++; if (ctl !== RED) begin errors++; $display("FAIL red_ctl got=%b exp=%b", ctl, RED); end
    tick();
    clear_inputs();
    #1;
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL red_flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL red_no_mdu_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL red_stall_cnt got=%0d exp=2", stall_cnt); end
    tick();
  endtask

  task automatic test_mdu();
    int n;
    id_mdu_start = 1;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL mdu_start_ctl got=%b exp=%b", ctl, DEF); end
    tick();
    id_mdu_start = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== FRZ) begin errors++; $display("FAIL mdu_freeze%0d_ctl got=%b exp=%b", i, ctl, FRZ); end
      tick();
    end
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL mdu_release_ctl got=%b exp=%b", ctl, DEF); end
    // second MDU op issued on the release cycle
    id_mdu_start = 1;
    tick();
    id_mdu_start = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!mdu_busy) break;
      n++;
      tick();
    end
    checks++; if (3 + n !== 6) begin errors++; $display("FAIL mdu_b2b_freeze got=%0d exp=6", 3 + n); end
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL mdu_b2b_release_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if (stall_cnt !== 16'd8) begin errors++; $display("FAIL mdu_stall_cnt got=%0d exp=8", stall_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_mdu();
    id_mdu_start = 1;
    tick();             // MDU_WAIT, cnt=3
    id_mdu_start = 0;
    tick();             // cnt=2
    #1;
    checks++; if (ctl !== FRZ) begin errors++; $display("FAIL rmdu_frozen_ctl got=%b exp=%b", ctl, FRZ); end
    rst = 1;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL rmdu_forced_ctl got=%b exp=%b", ctl, DEF); end
    tick();
    rst = 0;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL rmdu_run_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rmdu_stall_cnt got=%0d exp=0", stall_cnt); end
    tick();
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL rmdu_run2_ctl got=%b exp=%b", ctl, DEF); end
  endtask

  task automatic test_halt();
    ex_redirect = 1;
    tick();
    clear_inputs();
    set_load_use_rs();
    tick();
    clear_inputs();
    ex_halt = 1;
    #1;
    checks++; if (ctl !== HENT) begin errors++; $display("FAIL halt_entry_ctl got=%b exp=%b", ctl, HENT); end
    tick();
    for (int i = 0; i < 100; i++) begin
      {id_rs, id_rt, ex_wreg} = 15'($urandom);
      {id_uses_rs, id_uses_rt, id_mdu_start, ex_memread,
       ex_regwrite, ex_redirect, ex_halt} = 7'($urandom);
      #1;
      checks++; if (ctl !== HLTD) begin errors++; $display("FAIL halt_ctl[%0d] got=%b exp=%b", i, ctl, HLTD); end
      checks++; if ({stall_cnt, flush_cnt} !== {16'd2, 16'd1}) begin
        errors++; $display("FAIL halt_counters[%0d] got=%0d/%0d exp=2/1", i, stall_cnt, flush_cnt);
      end
      tick();
    end
    rst = 1;
    tick();
    rst = 0;
    clear_inputs();
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("FAIL halt_exit_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if ({stall_cnt, flush_cnt} !== 32'd0) begin
      errors++; $display("FAIL halt_exit_counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_saturation();
    set_load_use_rs();
    repeat (70000) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_stall_cnt got=%h exp=ffff", stall_cnt); end
    repeat (5) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_redirect_priority();
    test_mdu();
    test_reset_mid_mdu();
    test_halt();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
